range_bcd_conv: RTL and testbench

Sequential binary-to-BCD converter for the ultrasonic ranging path. It sits between the distance measurement stage, which produces the 16-bit `data` word, and the 7-segment display stage. It converts each new distance sample to four packed BCD digits using iterative shift-and-add-3, one bit per clock. Values above the display range saturate and raise an over-range flag, so the display driver only does digit-to-segment decoding.

---
 rtl/range_bcd_conv.sv | 133 +++++++++++++
 tb/tb_range_bcd_conv.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/range_bcd_conv.sv
// Sequential binary-to-BCD converter with saturation at MAX_DISP; 17 cycles from strobe to result.
// No backpressure: strobes arriving during a conversion go to a one-deep, newest-wins pending slot.
module range_bcd_conv #(
  parameter int MAX_DISP = 9999
) (
  input  logic        CLK_50M,
  input  logic        RST,
  input  logic [15:0] data_in,
  input  logic        data_stb,
  output logic [15:0] bcd_out,
  output logic        over_range,
  output logic        bcd_valid,
  output logic        busy
);

  localparam logic [15:0] MAX_VAL = 16'(MAX_DISP);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] work_q, work_d;
  logic        over_q, over_d;
  logic        pend_q, pend_d;
  logic [15:0] pend_dat_q, pend_dat_d;
  logic [15:0] bcd_out_q, bcd_out_d;
  logic        over_range_q, over_range_d;
  logic        bcd_valid_q, bcd_valid_d;
  logic        busy_q, busy_d;

  logic [15:0] cap_src;
  logic        cap_over;
  logic [15:0] cap_val;
  logic [31:0] work_adj;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // A live strobe always beats the pending slot, so capture reads data_in whenever it is present.
  always_comb begin
    cap_src  = data_stb ? data_in : pend_dat_q;
    cap_over = (cap_src > MAX_VAL);
    cap_val  = cap_over ? MAX_VAL : cap_src;
    work_adj = {add3(work_q[31:16]), work_q[15:0]};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    work_d       = work_q;
    over_d       = over_q;
    pend_d       = pend_q;
    pend_dat_d   = pend_dat_q;
    bcd_out_d    = bcd_out_q;
    over_range_d = over_range_q;
    bcd_valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_stb) begin
          work_d  = {16'h0000, cap_val};
          over_d  = cap_over;
          cnt_d   = 4'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        work_d = {work_adj[30:0], 1'b0};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = DONE;
        if (data_stb) begin
          pend_d     = 1'b1;
          pend_dat_d = data_in;
        end
      end
      DONE: begin
        bcd_out_d    = work_q[31:16];
        over_range_d = over_q;
        bcd_valid_d  = 1'b1;
        pend_d       = 1'b0;
        if (data_stb || pend_q) begin
          work_d  = {16'h0000, cap_val};
          over_d  = cap_over;
          cnt_d   = 4'd0;
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      work_q       <= 32'h0;
      over_q       <= 1'b0;
      pend_q       <= 1'b0;
      pend_dat_q   <= 16'h0;
      bcd_out_q    <= 16'h0;
      over_range_q <= 1'b0;
      bcd_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      work_q       <= work_d;
      over_q       <= over_d;
      pend_q       <= pend_d;
      pend_dat_q   <= pend_dat_d;
      bcd_out_q    <= bcd_out_d;
      over_range_q <= over_range_d;
      bcd_valid_q  <= bcd_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bcd_out    = bcd_out_q;
  assign over_range = over_range_q;
  assign bcd_valid  = bcd_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_range_bcd_conv.sv
// Bench for range_bcd_conv: default-ceiling and MAX_DISP=400 instances share one stimulus stream.
module tb_range_bcd_conv;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic [15:0] din = 16'h0;

  logic [15:0] bcd_a, bcd_b;
  logic        ovr_a, ovr_b, vld_a, vld_b, busy_a, busy_b;

  range_bcd_conv dut_a (
    .CLK_50M(clk), .RST(rst), .data_in(din), .data_stb(stb),
    .bcd_out(bcd_a), .over_range(ovr_a), .bcd_valid(vld_a), .busy(busy_a)
  );

  range_bcd_conv #(.MAX_DISP(400)) dut_b (
    .CLK_50M(clk), .RST(rst), .data_in(din), .data_stb(stb),
    .bcd_out(bcd_b), .over_range(ovr_b), .bcd_valid(vld_b), .busy(busy_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: each accepted sample produces its result 17 edges later.
  int          mx[2] = '{9999, 400};
  bit          busy_m[2];
  int          cur[2];
  int          due[2];
  bit          pnd[2];
  int          pv[2];
  logic [15:0] e_bcd[2];
  bit          e_ovr[2];
  bit          e_vld[2];
  int          cyc = 0;
  bit          model_on = 0;

  function automatic logic [15:0] to_bcd(input int v, input int m);
    int s;
    s = (v > m) ? m : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  always begin
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        busy_m[k] = 0; pnd[k] = 0; e_bcd[k] = 16'h0; e_ovr[k] = 0; e_vld[k] = 0;
      end else if (model_on) begin
        e_vld[k] = 0;
        if (busy_m[k] && cyc == due[k]) begin
          e_bcd[k] = to_bcd(cur[k], mx[k]);
          e_ovr[k] = (cur[k] > mx[k]);
          e_vld[k] = 1;
          if (stb) begin
            cur[k] = int'(din); due[k] = cyc + 17;
          end else if (pnd[k]) begin
            cur[k] = pv[k]; due[k] = cyc + 17;
          end else begin
            busy_m[k] = 0;
          end
          pnd[k] = 0;
        end else if (busy_m[k]) begin
          if (stb) begin pnd[k] = 1; pv[k] = int'(din); end
        end else if (stb) begin
          busy_m[k] = 1; cur[k] = int'(din); due[k] = cyc + 17;
        end
      end
    end
    if (rst) model_on = 1;
    if (model_on) begin
      chk("model bcd_out a", bcd_a, e_bcd[0]);
      chk("model over_range a", ovr_a, e_ovr[0]);
      chk("model bcd_valid a", vld_a, e_vld[0]);
      chk("model busy a", busy_a, busy_m[0]);
      chk("model bcd_out b", bcd_b, e_bcd[1]);
      chk("model over_range b", ovr_b, e_ovr[1]);
      chk("model bcd_valid b", vld_b, e_vld[1]);
      chk("model busy b", busy_b, busy_m[1]);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      stb = 1'b0;
    end
  endtask

  task automatic run_one(input logic [15:0] v, input logic [15:0] ea, input logic oa,
                         input logic [15:0] eb, input logic ob);
    int lat;
    lat = -1;
    @(negedge clk);
    din = v;
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (vld_a === 1'b1) begin
        lat = k;
        chk("lit bcd_out a", bcd_a, ea);
        chk("lit over_range a", ovr_a, oa);
        chk("lit bcd_valid b", vld_b, 1'b1);
        chk("lit bcd_out b", bcd_b, eb);
        chk("lit over_range b", ovr_b, ob);
      end
    end
    chk("lit latency", lat, 17);
    @(negedge clk);
    chk("lit valid pulse width", vld_a, 1'b0);
    idle(2);
  endtask

  logic [15:0] tv [8] = '{16'd0, 16'd9, 16'd10, 16'd9999, 16'd10000, 16'd65535, 16'd401, 16'd1234};
  logic [15:0] ta [8] = '{16'h0000, 16'h0009, 16'h0010, 16'h9999, 16'h9999, 16'h9999, 16'h0401, 16'h1234};
  logic        toa[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [15:0] tb_[8] = '{16'h0000, 16'h0009, 16'h0010, 16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400};
  logic        tob[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int nv;
    int nb;

    // Reset held for 3 cycles with a strobe present
    rst = 1'b1;
    stb = 1'b1;
    din = 16'd1234;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    stb = 1'b0;
    nv = 0;
    repeat (20) begin
      @(negedge clk);
      if (vld_a === 1'b1) nv++;
    end
    chk("reset no valid", nv, 0);
    chk("reset bcd_out", bcd_a, 16'h0000);
    chk("reset over_range", ovr_a, 1'b0);
    chk("reset busy", busy_a, 1'b0);

    for (int i = 0; i < 8; i++) run_one(tv[i], ta[i], toa[i], tb_[i], tob[i]);

    // Buffering: 700 is overwritten by 800 in the pending slot
    nv = 0; nb = 0;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (vld_a === 1'b1) nv++;
      if (i >= 1 && i <= 34 && busy_a === 1'b1) nb++;
      if (i == 18) begin
        chk("buf first valid", vld_a, 1'b1);
        chk("buf first bcd", bcd_a, 16'h0500);
      end
      if (i == 35) begin
        chk("buf second valid", vld_a, 1'b1);
        chk("buf second bcd", bcd_a, 16'h0800);
      end
      stb = (i == 0 || i == 3 || i == 9);
      din = (i == 0) ? 16'd500 : (i == 3) ? 16'd700 : 16'd800;
    end
    chk("buf valid count", nv, 2);
    chk("buf busy continuous", nb, 34);

    // Strobe in DONE wins over the pending 300
    nv = 0;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (vld_a === 1'b1) nv++;
      if (i == 18) chk("coll first bcd", bcd_a, 16'h0250);
      if (i == 35) begin
        chk("coll second valid", vld_a, 1'b1);
        chk("coll second bcd", bcd_a, 16'h0042);
      end
      stb = (i == 0 || i == 5 || i == 17);
      din = (i == 0) ? 16'd250 : (i == 5) ? 16'd300 : 16'd42;
    end
    chk("coll valid count", nv, 2);

    // Reset in the middle of a conversion
    nv = 0;
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk);
      if (vld_a === 1'b1) nv++;
      stb = (i == 0);
      din = 16'd1234;
      rst = (i == 8);
    end
    chk("midrst no valid", nv, 0);
    chk("midrst bcd_out", bcd_a, 16'h0000);
    chk("midrst busy", busy_a, 1'b0);
    run_one(16'd77, 16'h0077, 1'b0, 16'h0077, 1'b0);

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
